// File: rtl/fb_pixel_writer.sv
// Write-side port of the 160x120 8bpp framebuffer: buffers CPU pixel writes in a
// small FIFO, converts (x,y) to a linear address and also performs a full-screen fill.
module fb_pixel_writer #(
  parameter int H_PIX      = 160,
  parameter int V_PIX      = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_x,
  input  logic [6:0]        req_y,
  input  logic [7:0]        req_color,
  input  logic              clr_start,
  input  logic [7:0]        clr_color,
  output logic              clr_done,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic              fb_we,
  input  logic              fb_grant,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int FILL_LAST = H_PIX * V_PIX - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [7:0]          fifo_data_q [FIFO_DEPTH];
  logic                clr_pend_q, clr_pend_d;
  logic [7:0]          clr_color_q, clr_color_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic                err_q, err_d;
  logic                clr_done_q, clr_done_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [7:0]          last_data_q, last_data_d;

  logic                fifo_full_s, fifo_empty_s;
  logic                accept_s, in_range_s, push_s, pop_s;
  logic                fill_step_s, fill_last_s;
  logic [ADDR_W-1:0]   req_addr_s, src_addr_s;
  logic [7:0]          src_data_s;
  logic                we_s;

  assign fifo_full_s  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  assign req_ready    = !fifo_full_s && !clr_pend_q && (state_q != ST_CLEAR);
  assign accept_s     = req_valid && req_ready;
  assign in_range_s   = (req_x < 8'(H_PIX)) && (req_y < 7'(V_PIX));
  assign push_s       = accept_s && in_range_s;
  assign pop_s        = (state_q == ST_WRITE) && fb_grant;
  assign fill_step_s  = (state_q == ST_CLEAR) && fb_grant;
  assign fill_last_s  = (fill_cnt_q == ADDR_W'(FILL_LAST));
  // y*160 + x without a multiplier: y*128 + y*32 + x
  assign req_addr_s   = ADDR_W'({req_y, 7'b0}) + ADDR_W'({req_y, 5'b0}) + ADDR_W'(req_x);

  // State register plus all datapath flops
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      clr_pend_q  <= 1'b0;
      clr_color_q <= 8'h00;
      fill_cnt_q  <= {ADDR_W{1'b0}};
      err_q       <= 1'b0;
      clr_done_q  <= 1'b0;
      last_addr_q <= {ADDR_W{1'b0}};
      last_data_q <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= {ADDR_W{1'b0}};
        fifo_data_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      clr_pend_q  <= clr_pend_d;
      clr_color_q <= clr_color_d;
      fill_cnt_q  <= fill_cnt_d;
      err_q       <= err_d;
      clr_done_q  <= clr_done_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      if (push_s) begin
        fifo_addr_q[wr_ptr_q] <= req_addr_s;
        fifo_data_q[wr_ptr_q] <= req_color;
      end
    end
  end

  // Next-state logic; a push seen in IDLE enters WRITE directly so fb_we rises one cycle after acceptance
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s || push_s) begin
          state_d = ST_WRITE;
        end else if (clr_pend_q) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (pop_s && (count_q == CNT_W'(1)) && !push_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_CLEAR: begin
        if (fill_step_s && fill_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: write source follows the state, the held copy covers idle cycles
  always_comb begin
    we_s       = 1'b0;
    src_addr_s = last_addr_q;
    src_data_s = last_data_q;
    case (state_q)
      ST_WRITE: begin
        we_s       = 1'b1;
        src_addr_s = fifo_addr_q[rd_ptr_q];
        src_data_s = fifo_data_q[rd_ptr_q];
      end
      ST_CLEAR: begin
        we_s       = 1'b1;
        src_addr_s = fill_cnt_q;
        src_data_s = clr_color_q;
      end
      default: begin
        we_s       = 1'b0;
        src_addr_s = last_addr_q;
        src_data_s = last_data_q;
      end
    endcase
  end

  // FIFO pointers, fill counter, clear request and sticky error
  always_comb begin
    wr_ptr_d    = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    clr_done_d  = fill_step_s && fill_last_s;
    clr_pend_d  = clr_pend_q;
    clr_color_d = clr_color_q;
    if (clr_done_d) begin
      clr_pend_d = 1'b0;
    end else if (clr_start && !clr_pend_q && (state_q != ST_CLEAR)) begin
      clr_pend_d  = 1'b1;
      clr_color_d = clr_color;
    end else begin
      clr_pend_d = clr_pend_q;
    end

    if (fill_step_s) begin
      fill_cnt_d = fill_last_s ? {ADDR_W{1'b0}} : fill_cnt_q + ADDR_W'(1);
    end else begin
      fill_cnt_d = fill_cnt_q;
    end

    if (err_clr) begin
      err_d = 1'b0;
    end else if (accept_s && !in_range_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    last_addr_d = we_s ? src_addr_s : last_addr_q;
    last_data_d = we_s ? src_data_s : last_data_q;
  end

  assign fb_we    = we_s;
  assign fb_addr  = src_addr_s;
  assign fb_data  = src_data_s;
  assign clr_done = clr_done_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE) || clr_pend_q || !fifo_empty_s;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: reset, single write, back-pressure,
// range errors, clear-screen fill and a random-grant scoreboard run.
module tb_fb_pixel_writer;

  logic        clkin = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [7:0]  req_x;
  logic [6:0]  req_y;
  logic [7:0]  req_color;
  logic        clr_start;
  logic [7:0]  clr_color;
  logic        clr_done, busy, err, err_clr;
  logic        fb_we, fb_grant;
  logic [14:0] fb_addr;
  logic [7:0]  fb_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          clr_done_cnt = 0;
  logic        rand_grant = 1'b0;
  logic [22:0] commit_q[$];

  fb_pixel_writer dut (
    .clkin(clkin), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .clr_start(clr_start), .clr_color(clr_color), .clr_done(clr_done),
    .busy(busy), .err(err), .err_clr(err_clr),
    .fb_we(fb_we), .fb_grant(fb_grant), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clkin = ~clkin;

  // Log committed writes and clr_done pulses mid-cycle
  always @(negedge clkin) begin
    if (fb_we && fb_grant) commit_q.push_back({fb_addr, fb_data});
    if (clr_done) clr_done_cnt++;
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic send_req(input logic [7:0] x, input logic [6:0] y, input logic [7:0] c);
    logic ok;
    ok = 1'b0;
    req_x = x; req_y = y; req_color = c; req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rand_grant) fb_grant = 1'($urandom_range(0, 1));
      if (req_ready) ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL send_req_timeout x=%0d y=%0d: not accepted, required acceptance", x, y); end
  endtask

  task automatic wait_idle(input int bound);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else begin
        if (rand_grant) fb_grant = 1'($urandom_range(0, 1));
        tick();
      end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wait_idle_timeout: busy=%0b, required 0", busy); end
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b0;
    repeat (2) tick();
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL rst_fb_we: got %0b want 0", fb_we); end
    reset = 1'b1;
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", err); end
    n_checks++; if (fb_addr !== 15'd0 || fb_data !== 8'h00) begin n_fail++; $display("FAIL rst_addr_data: got %0d/%h want 0/00", fb_addr, fb_data); end
    // start a fill and kill it with reset partway through
    fb_grant = 1'b1; clr_color = 8'h55; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) tick();
    n_checks++; if (fb_we !== 1'b1) begin n_fail++; $display("FAIL clear_running: fb_we=%0b want 1", fb_we); end
    reset = 1'b0;
    tick();
    n_checks++; if (fb_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clear: fb_we=%0b busy=%0b want 0/0", fb_we, busy); end
    reset = 1'b1;
    base = commit_q.size();
    repeat (40) tick();
    n_checks++; if (commit_q.size() !== base) begin n_fail++; $display("FAIL rst_no_writes: %0d writes after reset, want 0", commit_q.size() - base); end
    n_checks++; if (clr_done_cnt !== 0) begin n_fail++; $display("FAIL rst_no_clr_done: %0d pulses, want 0", clr_done_cnt); end
  endtask

  task automatic test_single_write();
    fb_grant = 1'b1;
    commit_q.delete();
    req_x = 8'd5; req_y = 7'd2; req_color = 8'hE3; req_valid = 1'b1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd325 || fb_data !== 8'hE3) begin
      n_fail++; $display("FAIL single_write: we=%0b addr=%0d data=%h want 1/325/e3", fb_we, fb_addr, fb_data); end
    tick();
    n_checks++; if (fb_we !== 1'b0 || fb_addr !== 15'd325) begin
      n_fail++; $display("FAIL single_hold: we=%0b addr=%0d want 0/325", fb_we, fb_addr); end
    n_checks++; if (commit_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", commit_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  xs [5];
    logic [6:0]  ys [5];
    logic [7:0]  cs [5];
    logic [14:0] as [5];
    xs = '{8'd1, 8'd2, 8'd10, 8'd0, 8'd159};
    ys = '{7'd0, 7'd1, 7'd3, 7'd5, 7'd0};
    cs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    as = '{15'd1, 15'd162, 15'd490, 15'd800, 15'd159};
    fb_grant = 1'b0;
    commit_q.delete();
    for (int i = 0; i < 4; i++) send_req(xs[i], ys[i], cs[i]);
    req_x = xs[4]; req_y = ys[4]; req_color = cs[4]; req_valid = 1'b1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %0b want 0", req_ready); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd1 || fb_data !== 8'h11) begin
        n_fail++; $display("FAIL bp_stall_stable: we=%0b addr=%0d data=%h want 1/1/11", fb_we, fb_addr, fb_data); end
      tick();
    end
    fb_grant = 1'b1;
    send_req(xs[4], ys[4], cs[4]);
    wait_idle(50);
    n_checks++; if (commit_q.size() !== 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", commit_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++; if (commit_q[i] !== {as[i], cs[i]}) begin
          n_fail++; $display("FAIL bp_order[%0d]: got %0d/%h want %0d/%h", i, commit_q[i][22:8], commit_q[i][7:0], as[i], cs[i]); end
      end
    end
  endtask

  task automatic test_range();
    fb_grant = 1'b1; err_clr = 1'b0;
    commit_q.delete();
    send_req(8'd160, 7'd0, 8'hAA);
    repeat (3) tick();
    n_checks++; if (err !== 1'b1 || commit_q.size() !== 0) begin
      n_fail++; $display("FAIL range_x: err=%0b writes=%0d want 1/0", err, commit_q.size()); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %0b want 0", err); end
    send_req(8'd0, 7'd120, 8'hBB);
    repeat (2) tick();
    n_checks++; if (err !== 1'b1 || commit_q.size() !== 0 || fb_we !== 1'b0) begin
      n_fail++; $display("FAIL range_y: err=%0b writes=%0d we=%0b want 1/0/0", err, commit_q.size(), fb_we); end
    err_clr = 1'b1; tick();
    // err_clr held while another bad request is accepted: clear must win
    send_req(8'd200, 7'd50, 8'hCC);
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr_wins: got %0b want 0", err); end
    send_req(8'd159, 7'd119, 8'h3C);
    send_req(8'd0, 7'd0, 8'hC3);
    wait_idle(20);
    n_checks++; if (commit_q.size() !== 2) begin n_fail++; $display("FAIL corner_count: got %0d want 2", commit_q.size()); end
    else begin
      n_checks++; if (commit_q[0] !== {15'd19199, 8'h3C}) begin
        n_fail++; $display("FAIL corner_max: got %0d/%h want 19199/3c", commit_q[0][22:8], commit_q[0][7:0]); end
      n_checks++; if (commit_q[1] !== {15'd0, 8'hC3}) begin
        n_fail++; $display("FAIL corner_zero: got %0d/%h want 0/c3", commit_q[1][22:8], commit_q[1][7:0]); end
    end
  endtask

  task automatic test_clear();
    int done0, viol, bad;
    logic finished;
    fb_grant = 1'b0;
    commit_q.delete();
    done0 = clr_done_cnt; viol = 0; bad = 0; finished = 1'b0;
    send_req(8'd7, 7'd7, 8'h01);
    send_req(8'd8, 7'd7, 8'h02);
    clr_color = 8'h1C; clr_start = 1'b1;
    tick();
    clr_start = 1'b0; clr_color = 8'hFF;
    n_checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_pend_stall: ready=%0b busy=%0b want 0/1", req_ready, busy); end
    fb_grant = 1'b1;
    for (int i = 0; i < 19400 && !finished; i++) begin
      clr_start = (i == 100);
      tick();
      if (clr_done) finished = 1'b1;
      else if (req_ready) viol++;
    end
    clr_start = 1'b0;
    repeat (3) tick();
    n_checks++; if (!finished) begin n_fail++; $display("FAIL clr_timeout: clr_done not seen, required a pulse"); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL clr_ready_low: ready high %0d cycles, want 0", viol); end
    n_checks++; if (clr_done_cnt - done0 !== 1) begin n_fail++; $display("FAIL clr_done_pulses: got %0d want 1", clr_done_cnt - done0); end
    n_checks++; if (commit_q.size() !== 19202) begin n_fail++; $display("FAIL clr_count: got %0d want 19202", commit_q.size()); end
    else begin
      n_checks++; if (commit_q[0] !== {15'd1127, 8'h01} || commit_q[1] !== {15'd1128, 8'h02}) begin
        n_fail++; $display("FAIL clr_drain_first: got %0d,%0d want 1127,1128", commit_q[0][22:8], commit_q[1][22:8]); end
      for (int i = 0; i < 19200; i++) begin
        if (commit_q[i + 2] !== {15'(i), 8'h1C}) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clr_fill_data: %0d wrong fill writes, want 0", bad); end
    end
    n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_after: ready=%0b busy=%0b want 1/0", req_ready, busy); end
  endtask

  task automatic test_random();
    logic [7:0] exp_mem [int];
    logic [7:0] act_mem [int];
    int n_exp;
    logic [7:0] x, c;
    logic [6:0] y;
    n_exp = 0;
    commit_q.delete();
    rand_grant = 1'b1;
    for (int i = 0; i < 150; i++) begin
      x = 8'($urandom_range(0, 169));
      y = 7'($urandom_range(0, 124));
      c = 8'($urandom_range(0, 255));
      send_req(x, y, c);
      if (x < 8'd160 && y < 7'd120) begin
        exp_mem[int'(y) * 160 + int'(x)] = c;
        n_exp++;
      end
    end
    wait_idle(1000);
    rand_grant = 1'b0; fb_grant = 1'b1;
    n_checks++; if (commit_q.size() !== n_exp) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", commit_q.size(), n_exp); end
    foreach (commit_q[i]) act_mem[int'(commit_q[i][22:8])] = commit_q[i][7:0];
    n_checks++; if (act_mem.num() !== exp_mem.num()) begin n_fail++; $display("FAIL rand_locations: got %0d want %0d", act_mem.num(), exp_mem.num()); end
    foreach (exp_mem[a]) begin
      n_checks++;
      if (!act_mem.exists(a)) begin n_fail++; $display("FAIL rand_missing addr=%0d: not written, want %h", a, exp_mem[a]); end
      else if (act_mem[a] !== exp_mem[a]) begin n_fail++; $display("FAIL rand_data addr=%0d: got %h want %h", a, act_mem[a], exp_mem[a]); end
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_x = 8'd0; req_y = 7'd0; req_color = 8'h00;
    clr_start = 1'b0; clr_color = 8'h00; err_clr = 1'b0; fb_grant = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_range();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
